// File: rtl/pwm_bank.sv
// Multi-channel PWM timer bank: edge/center-aligned counters, period-boundary
// shadow reload, and complementary outputs with dead-time insertion.
//
// state | meaning
// IDLE  | ch_en=0: counter/outputs held at 0, shadows track the inputs
// RUN   | ch_en=1: counting, shadows frozen except at the period boundary
module pwm_bank #(
    parameter int CH_NUM     = 8,
    parameter int CNT_LENGTH = 16,
    parameter int DT_LENGTH  = 8
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [CH_NUM-1:0]            ch_en,
    input  logic [CH_NUM-1:0]            ch_mode,
    input  logic [CH_NUM*CNT_LENGTH-1:0] max_val,
    input  logic [CH_NUM*CNT_LENGTH-1:0] duty_cycle,
    input  logic [CH_NUM*DT_LENGTH-1:0]  dead_time,
    output logic [CH_NUM-1:0]            pwm_pos,
    output logic [CH_NUM-1:0]            pwm_neg,
    output logic [CH_NUM-1:0]            upd_evt
);

    localparam logic [CNT_LENGTH-1:0] CNT_ONE = CNT_LENGTH'(1);
    localparam logic [DT_LENGTH-1:0]  DT_ONE  = DT_LENGTH'(1);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [CNT_LENGTH-1:0] cnt;
        logic [CNT_LENGTH-1:0] max_s;
        logic [CNT_LENGTH-1:0] duty_s;
        logic [DT_LENGTH-1:0]  dt_s;
        logic [DT_LENGTH-1:0]  dtc;
        logic                  mode_s;
        logic                  dir;
        logic                  raw;
        logic                  raw_q;
        logic                  boundary;
        logic                  pos;
        logic                  neg;
        logic                  upd;
        logic [CNT_LENGTH-1:0] max_in;
        logic [CNT_LENGTH-1:0] duty_in;
        logic [DT_LENGTH-1:0]  dt_in;

        assign max_in  = max_val[i*CNT_LENGTH +: CNT_LENGTH];
        assign duty_in = duty_cycle[i*CNT_LENGTH +: CNT_LENGTH];
        assign dt_in   = dead_time[i*DT_LENGTH +: DT_LENGTH];

        assign raw = (cnt < duty_s);

        // In center mode with max_s==1 the peak is also the last cycle before the valley.
        always_comb begin
            boundary = 1'b0;
            if (max_s == '0)
                boundary = 1'b1;
            else if (!mode_s)
                boundary = (cnt == max_s);
            else
                boundary = (cnt == CNT_ONE) && (dir || (max_s == CNT_ONE));
        end

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                cnt    <= '0;
                dir    <= 1'b0;
                max_s  <= '0;
                duty_s <= '0;
                dt_s   <= '0;
                mode_s <= 1'b0;
                dtc    <= '0;
                raw_q  <= 1'b0;
                pos    <= 1'b0;
                neg    <= 1'b0;
                upd    <= 1'b0;
            end else if (!ch_en[i]) begin
                cnt    <= '0;
                dir    <= 1'b0;
                max_s  <= max_in;
                duty_s <= duty_in;
                dt_s   <= dt_in;
                mode_s <= ch_mode[i];
                dtc    <= '0;
                raw_q  <= 1'b0;
                pos    <= 1'b0;
                neg    <= 1'b0;
                upd    <= 1'b0;
            end else begin
                raw_q <= raw;
                upd   <= boundary;

                if (boundary) begin
                    cnt    <= '0;
                    dir    <= 1'b0;
                    max_s  <= max_in;
                    duty_s <= duty_in;
                    dt_s   <= dt_in;
                    mode_s <= ch_mode[i];
                end else if (mode_s && !dir && (cnt == max_s)) begin
                    cnt <= cnt - CNT_ONE;
                    dir <= 1'b1;
                end else if (mode_s && dir) begin
                    cnt <= cnt - CNT_ONE;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end

                // dtc==1 releases the asserting output so the delay is exactly dt_s cycles.
                if (raw != raw_q) begin
                    if (dt_s == '0) begin
                        pos <= raw;
                        neg <= ~raw;
                        dtc <= '0;
                    end else begin
                        pos <= 1'b0;
                        neg <= 1'b0;
                        dtc <= dt_s;
                    end
                end else if (dtc > DT_ONE) begin
                    dtc <= dtc - DT_ONE;
                    pos <= 1'b0;
                    neg <= 1'b0;
                end else begin
                    dtc <= '0;
                    pos <= raw;
                    neg <= ~raw;
                end
            end
        end

        assign pwm_pos[i] = pos;
        assign pwm_neg[i] = neg;
        assign upd_evt[i] = upd;
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: table of per-channel configurations with
// expected period/high-time counts, plus reload, disable, reset and mode sequences.
module tb_pwm_bank;
    localparam int CH = 8;
    localparam int CW = 16;
    localparam int DW = 8;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [CH-1:0]     ch_en;
    logic [CH-1:0]     ch_mode;
    logic [CH*CW-1:0]  max_val;
    logic [CH*CW-1:0]  duty_cycle;
    logic [CH*DW-1:0]  dead_time;
    logic [CH-1:0]     pwm_pos;
    logic [CH-1:0]     pwm_neg;
    logic [CH-1:0]     upd_evt;

    pwm_bank #(.CH_NUM(CH), .CNT_LENGTH(CW), .DT_LENGTH(DW)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .ch_en      (ch_en),
        .ch_mode    (ch_mode),
        .max_val    (max_val),
        .duty_cycle (duty_cycle),
        .dead_time  (dead_time),
        .pwm_pos    (pwm_pos),
        .pwm_neg    (pwm_neg),
        .upd_evt    (upd_evt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit mode;
        int mx;
        int duty;
        int dt;
        int win;
        int period;
        int pos_n;
        int neg_n;
        int upd_n;
    } vec_t;

    vec_t vecs[10];
    vec_t sb[$];

    int n_vec   = 0;
    int n_err   = 0;
    int overlap = 0;

    always @(negedge sys_clk) if ((pwm_pos & pwm_neg) != '0) overlap++;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_ch(input int c, input bit mode, input int mx, input int duty, input int dt);
        ch_mode[c]              = mode;
        max_val[c*CW +: CW]     = CW'(mx);
        duty_cycle[c*CW +: CW]  = CW'(duty);
        dead_time[c*DW +: DW]   = DW'(dt);
    endtask

    // Steps until upd_evt[c] is seen; gap = steps taken, -1 on timeout.
    task automatic wait_upd(input int c, input int limit, output int gap);
        gap = -1;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (upd_evt[c]) begin
                gap = k;
                return;
            end
        end
    endtask

    initial begin
        int   g;
        int   c;
        int   pn;
        int   nn;
        int   un;
        vec_t e;

        //            mode mx duty dt win per pos neg upd
        vecs[0] = '{1'b0,  9,  3, 0, 10, 10,  3,  7,  1};
        vecs[1] = '{1'b1,  4,  2, 0,  8,  8,  3,  5,  1};
        vecs[2] = '{1'b0, 19, 10, 3, 20, 20,  7,  7,  1};
        vecs[3] = '{1'b0,  9,  0, 0, 10, 10,  0, 10,  1};
        vecs[4] = '{1'b0,  9, 10, 0, 10, 10, 10,  0,  1};
        vecs[5] = '{1'b0,  0,  0, 0, 10,  1,  0, 10, 10};
        vecs[6] = '{1'b0,  9,  2, 5, 10, 10,  0,  3,  1};
        vecs[7] = '{1'b1,  1,  1, 0,  2,  2,  1,  1,  1};
        vecs[8] = '{1'b1,  5,  6, 0, 10, 10, 10,  0,  1};
        vecs[9] = '{1'b1,  6,  3, 2, 12, 12,  3,  5,  1};

        sys_rst    = 1'b1;
        ch_en      = '0;
        ch_mode    = '0;
        max_val    = '0;
        duty_cycle = '0;
        dead_time  = '0;
        #12;
        check("reset_outputs", int'({pwm_pos, pwm_neg, upd_evt}), 0);
        sys_rst = 1'b0;
        step();

        for (int v = 0; v < 10; v++) begin
            c = v % 3;
            ch_en[c] = 1'b0;
            set_ch(c, vecs[v].mode, vecs[v].mx, vecs[v].duty, vecs[v].dt);
            step();
            step();
            ch_en[c] = 1'b1;
            sb.push_back(vecs[v]);
            wait_upd(c, 100, g);
            wait_upd(c, 100, g);
            e = sb.pop_front();
            check($sformatf("v%0d_period", v), g, e.period);
            pn = 0; nn = 0; un = 0;
            for (int k = 0; k < e.win; k++) begin
                pn += int'(pwm_pos[c]);
                nn += int'(pwm_neg[c]);
                un += int'(upd_evt[c]);
                step();
            end
            check($sformatf("v%0d_pos_high", v), pn, e.pos_n);
            check($sformatf("v%0d_neg_high", v), nn, e.neg_n);
            check($sformatf("v%0d_upd_count", v), un, e.upd_n);
        end

        // Shadow reload: duty write at cnt=5 must wait for the boundary.
        ch_en[0] = 1'b0;
        set_ch(0, 1'b0, 9, 3, 0);
        step();
        step();
        ch_en[0] = 1'b1;
        wait_upd(0, 50, g);
        check("reload_first_upd", g, 10);
        for (int k = 0; k < 5; k++) step();
        duty_cycle[0 +: CW] = CW'(8);
        pn = 0; un = 0;
        for (int k = 0; k < 5; k++) begin
            pn += int'(pwm_pos[0]);
            un += int'(upd_evt[0]);
            step();
        end
        check("reload_old_period_pos", pn, 0);
        check("reload_old_period_upd", un, 0);
        check("reload_upd_at_boundary", int'(upd_evt[0]), 1);
        pn = 0;
        for (int k = 0; k < 10; k++) begin
            pn += int'(pwm_pos[0]);
            step();
        end
        check("reload_new_period_pos", pn, 8);

        // Disable at cnt=4 mid-pulse, then re-enable restarts from cnt=0.
        for (int k = 0; k < 4; k++) step();
        check("disable_pos_before", int'(pwm_pos[0]), 1);
        ch_en[0] = 1'b0;
        step();
        check("disable_outputs", int'({pwm_pos[0], pwm_neg[0], upd_evt[0]}), 0);
        step();
        ch_en[0] = 1'b1;
        wait_upd(0, 50, g);
        check("reenable_first_upd", g, 10);

        // Mode change through reload: edge -> center max=4 gives period 8.
        ch_mode[0] = 1'b1;
        max_val[0 +: CW] = CW'(4);
        duty_cycle[0 +: CW] = CW'(2);
        wait_upd(0, 50, g);
        check("mode_change_old_period", g, 10);
        wait_upd(0, 50, g);
        check("mode_change_new_period", g, 8);

        // Asynchronous reset in the middle of a pos pulse.
        g = -1;
        for (int k = 1; k <= 20; k++) begin
            if (pwm_pos[0]) begin
                g = k;
                break;
            end
            step();
        end
        check("reset_pulse_found", int'(g > 0), 1);
        #3;
        sys_rst = 1'b1;
        #1;
        check("async_reset_outputs", int'({pwm_pos, pwm_neg, upd_evt}), 0);
        step();
        sys_rst = 1'b0;
        step();

        check("no_overlap", overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
